// File: rtl/skew_feeder.sv
// Skew feeder: buffers 4x4 complex matrices column-wise in two ping-pong banks
// and replays each one as 7 diagonally skewed beats for a systolic QR array.
module skew_feeder #(
  parameter int WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] col_in_1_r,
  input  logic signed [WIDTH-1:0] col_in_1_i,
  input  logic signed [WIDTH-1:0] col_in_2_r,
  input  logic signed [WIDTH-1:0] col_in_2_i,
  input  logic signed [WIDTH-1:0] col_in_3_r,
  input  logic signed [WIDTH-1:0] col_in_3_i,
  input  logic signed [WIDTH-1:0] col_in_4_r,
  input  logic signed [WIDTH-1:0] col_in_4_i,
  output logic                    out_valid,
  output logic                    out_start,
  output logic [3:0]              lane_valid,
  output logic signed [WIDTH-1:0] row_out_1_r,
  output logic signed [WIDTH-1:0] row_out_1_i,
  output logic signed [WIDTH-1:0] row_out_2_r,
  output logic signed [WIDTH-1:0] row_out_2_i,
  output logic signed [WIDTH-1:0] row_out_3_r,
  output logic signed [WIDTH-1:0] row_out_3_i,
  output logic signed [WIDTH-1:0] row_out_4_r,
  output logic signed [WIDTH-1:0] row_out_4_i
);

  typedef enum logic {IDLE, EMIT} state_t;

  logic signed [WIDTH-1:0] col_r [4];
  logic signed [WIDTH-1:0] col_i [4];
  logic signed [WIDTH-1:0] bank_r [2][4][4];
  logic signed [WIDTH-1:0] bank_i [2][4][4];

  logic       wb, rb, rb_nxt;
  logic [1:0] wc;
  logic [1:0] full, full_nxt;
  logic       wr_fire, bank_free;
  state_t     state, state_nxt;
  logic [2:0] t, t_nxt;
  logic       emit_nxt;
  logic [3:0] diff;
  logic [3:0] lane_vld_nxt;
  logic signed [WIDTH-1:0] lane_r_nxt [4];
  logic signed [WIDTH-1:0] lane_i_nxt [4];
  logic signed [WIDTH-1:0] out_r [4];
  logic signed [WIDTH-1:0] out_i [4];

  assign col_r[0] = col_in_1_r;
  assign col_i[0] = col_in_1_i;
  assign col_r[1] = col_in_2_r;
  assign col_i[1] = col_in_2_i;
  assign col_r[2] = col_in_3_r;
  assign col_i[2] = col_in_3_i;
  assign col_r[3] = col_in_4_r;
  assign col_i[3] = col_in_4_i;

  assign in_ready = !full[wb];
  assign wr_fire  = in_valid && in_ready;

  // Writer: column wc of bank wb
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        bank_r[wb][k][wc] <= col_r[k];
        bank_i[wb][k][wc] <= col_i[k];
      end
    end
  end

  // Writer and emitter never touch the same bank in one edge, so both updates merge.
  always_comb begin
    full_nxt = full;
    if (bank_free) full_nxt[rb] = 1'b0;
    if (wr_fire && wc == 2'd3) full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wb   <= 1'b0;
      wc   <= 2'd0;
      full <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wc <= wc + 2'd1;
        if (wc == 2'd3) wb <= ~wb;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    rb_nxt    = rb;
    bank_free = 1'b0;
    case (state)
      IDLE: begin
        if (full[rb]) begin
          state_nxt = EMIT;
          t_nxt     = 3'd0;
        end
      end
      EMIT: begin
        if (t == 3'd6) begin
          bank_free = 1'b1;
          rb_nxt    = ~rb;
          t_nxt     = 3'd0;
          state_nxt = full[~rb] ? EMIT : IDLE;
        end else begin
          t_nxt = t + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next beat so they line up with the FSM state.
  always_comb begin
    emit_nxt     = (state_nxt == EMIT);
    diff         = 4'd0;
    lane_vld_nxt = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      diff            = {1'b0, t_nxt} - 4'(k);
      lane_vld_nxt[k] = emit_nxt && (diff <= 4'd3);
      lane_r_nxt[k]   = lane_vld_nxt[k] ? bank_r[rb_nxt][k][diff[1:0]] : '0;
      lane_i_nxt[k]   = lane_vld_nxt[k] ? bank_i[rb_nxt][k][diff[1:0]] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      t          <= 3'd0;
      rb         <= 1'b0;
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      lane_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        out_r[k] <= '0;
        out_i[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      rb         <= rb_nxt;
      out_valid  <= emit_nxt;
      out_start  <= emit_nxt && (t_nxt == 3'd0);
      lane_valid <= lane_vld_nxt;
      for (int k = 0; k < 4; k++) begin
        out_r[k] <= lane_r_nxt[k];
        out_i[k] <= lane_i_nxt[k];
      end
    end
  end

  assign row_out_1_r = out_r[0];
  assign row_out_1_i = out_i[0];
  assign row_out_2_r = out_r[1];
  assign row_out_2_i = out_i[1];
  assign row_out_3_r = out_r[2];
  assign row_out_3_i = out_i[2];
  assign row_out_4_r = out_r[3];
  assign row_out_4_i = out_i[3];

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: matrix-level reference model with expected-beat
// scoreboard, driven by directed and randomized column streams.
module tb_skew_feeder;
  localparam int W = 14;
  localparam int MW = 16 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, out_start;
  logic [3:0] lane_valid;
  logic signed [W-1:0] ci_r [4];
  logic signed [W-1:0] ci_i [4];
  logic signed [W-1:0] ro_r [4];
  logic signed [W-1:0] ro_i [4];

  always #5 clk = ~clk;

  skew_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .col_in_1_r(ci_r[0]), .col_in_1_i(ci_i[0]), .col_in_2_r(ci_r[1]), .col_in_2_i(ci_i[1]),
    .col_in_3_r(ci_r[2]), .col_in_3_i(ci_i[2]), .col_in_4_r(ci_r[3]), .col_in_4_i(ci_i[3]),
    .out_valid(out_valid), .out_start(out_start), .lane_valid(lane_valid),
    .row_out_1_r(ro_r[0]), .row_out_1_i(ro_i[0]), .row_out_2_r(ro_r[1]), .row_out_2_i(ro_i[1]),
    .row_out_3_r(ro_r[2]), .row_out_3_i(ro_i[2]), .row_out_4_r(ro_r[3]), .row_out_4_i(ro_i[3])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: whole matrices with their scheduled first-beat cycle.
  int cyc = 0;
  int start_q [$];
  logic [MW-1:0] re_q [$];
  logic [MW-1:0] im_q [$];
  int stored = 0;
  int last_start = -100;
  logic [MW-1:0] p_re, p_im;
  int p_cols = 0;

  always @(negedge clk) begin
    logic ready_exp, vld_exp;
    int b, c, st;
    logic [3:0] lv_exp;
    logic [8*W-1:0] d_exp, d_act;
    logic [MW-1:0] cur_re, cur_im;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      d_act[2*k*W +: W]     = ro_r[k];
      d_act[(2*k+1)*W +: W] = ro_i[k];
    end
    if (rst_n) begin
      chk("reset_state", 128'({out_valid, out_start, lane_valid, in_ready, d_act}),
          128'({1'b0, 1'b0, 4'b0000, 1'b1, {8*W{1'b0}}}));
      start_q.delete(); re_q.delete(); im_q.delete();
      stored = 0; last_start = -100; p_cols = 0;
    end else begin
      ready_exp = (stored < 2);
      chk("in_ready", 128'(in_ready), 128'(ready_exp));
      vld_exp = (start_q.size() > 0) && (cyc >= start_q[0]);
      chk("out_valid", 128'(out_valid), 128'(vld_exp));
      if (vld_exp) begin
        b = cyc - start_q[0];
        cur_re = re_q[0];
        cur_im = im_q[0];
        lv_exp = 4'b0000;
        d_exp = '0;
        for (int k = 0; k < 4; k++) begin
          c = b - k;
          if (c >= 0 && c <= 3) begin
            lv_exp[k] = 1'b1;
            d_exp[2*k*W +: W]     = cur_re[(k*4+c)*W +: W];
            d_exp[(2*k+1)*W +: W] = cur_im[(k*4+c)*W +: W];
          end
        end
        if (out_valid) begin
          chk("beat_ctl", 128'({out_start, lane_valid}), 128'({b == 0, lv_exp}));
          chk("beat_data", 128'(d_act), 128'(d_exp));
        end
        if (b == 6) begin
          void'(start_q.pop_front()); void'(re_q.pop_front()); void'(im_q.pop_front());
          stored--;
        end
      end else if (!out_valid) begin
        chk("idle_zero", 128'({out_start, lane_valid, d_act}), 128'(0));
      end
      if (in_valid && ready_exp) begin
        for (int k = 0; k < 4; k++) begin
          p_re[(k*4+p_cols)*W +: W] = ci_r[k];
          p_im[(k*4+p_cols)*W +: W] = ci_i[k];
        end
        p_cols++;
        if (p_cols == 4) begin
          st = (cyc + 2 > last_start + 7) ? cyc + 2 : last_start + 7;
          start_q.push_back(st); re_q.push_back(p_re); im_q.push_back(p_im);
          last_start = st;
          stored++;
          p_cols = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // mode 0: continuous, 1: toggled valid, 2: random gaps
  task automatic send_matrix(input logic [MW-1:0] re, input logic [MW-1:0] im,
                             input int mode, input int ncols);
    int c = 0;
    int tries = 0;
    int ph = 0;
    while (c < ncols) begin
      @(posedge clk); #1;
      tries++;
      if (tries > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got no acceptance in 300 cycles, required column %0d accepted", c);
        in_valid = 1'b0;
        return;
      end
      if ((mode == 1 && ph[0]) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          ci_r[k] = W'($urandom);
          ci_i[k] = W'($urandom);
        end
      end else begin
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
          ci_r[k] = re[(k*4+c)*W +: W];
          ci_i[k] = im[(k*4+c)*W +: W];
        end
      end
      ph++;
      @(negedge clk);
      if (in_valid && in_ready) c++;
    end
  endtask

  function automatic logic [MW-1:0] pattern(input int sgn, input int salt);
    logic [MW-1:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*W +: W] = W'(sgn * (16*r + c + salt));
    return m;
  endfunction

  function automatic logic [MW-1:0] extremes(input int flip);
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++)
      m[i*W +: W] = ((i + flip) % 2 == 0) ? W'(-8192) : W'(8191);
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  initial begin
    int w;
    for (int k = 0; k < 4; k++) begin
      ci_r[k] = '0;
      ci_i[k] = '0;
    end
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    send_matrix(pattern(1, 0), pattern(-1, 0), 0, 4);
    idle(12);
    send_matrix(extremes(0), extremes(1), 0, 4);
    idle(12);
    for (int m = 0; m < 3; m++) send_matrix(pattern(1, 100 * m), pattern(-1, 100 * m), 0, 4);
    idle(30);
    send_matrix(pattern(1, 7), pattern(-1, 7), 1, 4);
    idle(12);
    for (int m = 0; m < 8; m++) begin
      send_matrix(rand_mat(), rand_mat(), 2, 4);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 10));
    end
    idle(1);

    // Reset during beat t=3 with the other bank half loaded
    send_matrix(pattern(1, 3), pattern(-1, 3), 0, 4);
    send_matrix(rand_mat(), rand_mat(), 0, 2);
    idle(1);
    w = 0;
    while (!(out_valid && lane_valid == 4'b1111) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reach_t3", 128'(w < 50), 128'(1));
    #1 rst_n = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    send_matrix(pattern(1, 200), pattern(-1, 200), 0, 4);
    idle(1);

    w = 0;
    while (start_q.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 128'(start_q.size()), 128'(0));
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter: WIDTH, 14, bit width of each real or imaginary sample (two's complement).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-high reset (name kept for consistency; asserted = 1).
REQ-004 SHALL have port: in_valid  input  1  column beat offered.
REQ-005 SHALL have port: in_ready  output  1  column beat can be accepted.
REQ-006 SHALL have port: col_in_k_r / col_in_k_i (k=1..4)  input  WIDTH each  element (row k) of the offered column.
REQ-007 SHALL have port: out_valid  output  1  skewed beat present; drives the QR array in_valid.
REQ-008 SHALL have port: out_start  output  1  one-cycle pulse on the first beat of each matrix.
REQ-009 SHALL have port: lane_valid  output  4  bit k-1 = lane k carries a real element this beat.
REQ-010 SHALL have port: row_out_k_r / row_out_k_i (k=1..4)  output  WIDTH each  skewed element for array row k.

Function
REQ-011 SHALL accept a 4x4 complex matrix as 4 column beats, column 0 first; a beat transfers when in_valid && in_ready at a clock edge.
REQ-012 SHALL store matrices in two banks (ping-pong), each 16 complex entries; write-bank pointer wb, column counter wc (0..3), per-bank full flag.
REQ-013 SHALL drive in_ready = !full[wb], combinationally from registers only (no dependence on in_valid).
REQ-014 SHALL, on the beat with wc==3, set full[wb], toggle wb, and reset wc to 0.
REQ-015 SHALL implement emitter FSM states IDLE and EMIT with 3-bit beat counter t (0..6) and read-bank pointer rb.
REQ-016 SHALL leave IDLE for EMIT with t=0 at the edge where full[rb] is sampled high; first out_valid beat is visible in the cycle after that edge (one idle cycle after the 4th column edge).
REQ-017 SHALL, in EMIT at beat t, drive lane k with element (row k, column t-(k-1)) when 0 <= t-(k-1) <= 3, setting lane_valid[k-1]; otherwise drive 0 and clear lane_valid[k-1].
REQ-018 SHALL hold out_valid=1 for all 7 beats t=0..6, and out_start=1 only at t=0.
REQ-019 SHALL, at the edge ending t=6, clear full[rb] and toggle rb; if the other bank is full at that edge, continue with t=0 of the next matrix with no gap, else return to IDLE.
REQ-020 SHALL register all outputs; row_out, lane_valid, out_start are 0 whenever out_valid=0.
REQ-021 SHALL allow a bank-free (emitter) and a bank-fill (writer) in the same edge; they always address different banks, and in_ready reflects the freed bank from the next cycle.
REQ-022 SHALL pass samples bit-exact (no scaling, rounding or sign change).
REQ-023 SHALL ignore in_valid while in_ready=0; inputs are not captured and wc does not advance.

Reset
REQ-024 SHALL, while rst_n=1, force wb=rb=0, wc=0, full=00, FSM=IDLE, t=0, out_valid=0, out_start=0, lane_valid=0, all row_out=0, in_ready=1 after release.
REQ-025 SHALL discard any partially written or partially emitted matrix on reset mid-operation; bank contents need not be cleared.

Verification
REQ-026 Single matrix, element(r,c)=(16r+c) real, -(16r+c) imag, in_valid 4 consecutive cycles -> one idle cycle, then 7 beats; lane 1 = 0,1,2,3,0,0,0 (real); lane 4 = 0,0,0,48,49,50,51; lane_valid beats = 0001,0011,0111,1111,1110,1100,1000.
REQ-027 Three matrices streamed with in_valid held 1 -> in_ready drops after the 8th column, rises again after the first matrix's t=6; outputs are 21 contiguous out_valid beats with out_start at beats 0, 7, 14.
REQ-028 Sign/extreme values: element = -8192 (WIDTH=14 min) and 8191 on all lanes -> output values bit-identical.
REQ-029 Gapped input: in_valid toggled 1,0,1,0,... -> emission starts only after the 4th accepted column; wc never advances on in_valid=0 cycles.
REQ-030 Reset asserted at t=3 of emission with the second bank half loaded -> next cycle out_valid=0, in_ready=1; a fresh matrix after release emits correctly starting from bank 0.
